// File: rtl/alu_issue_queue_pkg.sv
// alu_issue_queue_pkg: shared types for the ALU issue queue.
// Holds the uop bundle, writeback broadcast, queue entry and ALU0-only classification.
package alu_issue_queue_pkg;
    localparam int PRF_AW   = 6;
    localparam int IQ_DEPTH = 8;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_LOGIC,
        ALU_SHIFT,
        ALU_BRANCH,
        ALU_CP0
    } ALUType;

    typedef enum logic [3:0] {
        UOP_NOP,
        UOP_ADDU,
        UOP_SUBU,
        UOP_ORI,
        UOP_SLL,
        UOP_BEQ,
        UOP_BNE,
        UOP_MTC0
    } UOPType;

    typedef struct packed {
        logic              valid;
        UOPType            uOP;
        ALUType            aluType;
        logic [PRF_AW-1:0] op0PAddr;
        logic [PRF_AW-1:0] op1PAddr;
        logic              op0re;
        logic              op1re;
        logic [PRF_AW-1:0] dstPAddr;
        logic              dstwe;
    } UOPBundle;

    typedef struct packed {
        logic              wen;
        logic [PRF_AW-1:0] rd;
    } PRFwInfo;

    typedef struct packed {
        logic     valid;
        logic     src0_rdy;
        logic     src1_rdy;
        UOPBundle uop;
    } IQEntry;

    function automatic logic isAlu0Only(input ALUType t);
        return t == ALU_BRANCH || t == ALU_CP0;
    endfunction
endpackage

// File: rtl/alu_issue_queue_select.sv
// iq_select: oldest-first picker for the two ALU pipes.
// ALU1 skips ALU0-only entries and whatever ALU0 already took.
module iq_select #(
    parameter int DEPTH = 8,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0] elig_i,
    input  logic [DEPTH-1:0] a0only_i,
    output logic             g0_o,
    output logic [IDX_W-1:0] idx0_o,
    output logic             g1_o,
    output logic [IDX_W-1:0] idx1_o
);
    always_comb begin
        g0_o   = 1'b0;
        idx0_o = '0;
        g1_o   = 1'b0;
        idx1_o = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (elig_i[i]) begin
                g0_o   = 1'b1;
                idx0_o = IDX_W'(i);
            end
        end
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (elig_i[i] && !a0only_i[i] && !(g0_o && idx0_o == IDX_W'(i))) begin
                g1_o   = 1'b1;
                idx1_o = IDX_W'(i);
            end
        end
    end
endmodule

// File: rtl/alu_issue_queue.sv
// alu_issue_queue: collapsing, oldest-first dual-issue scheduler for ALU0/ALU1.
// Entry 0 is always the oldest; issued entries are squeezed out each cycle.
module alu_issue_queue
    import alu_issue_queue_pkg::*;
#(
    parameter int DEPTH = IQ_DEPTH,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             enq_valid,
    input  UOPBundle         enq_uop,
    input  logic             enq_src0_rdy,
    input  logic             enq_src1_rdy,
    output logic             enq_ready,
    input  PRFwInfo          wake0,
    input  PRFwInfo          wake1,
    output UOPBundle         iss0,
    output UOPBundle         iss1,
    output logic [CNT_W-1:0] occupancy
);
    localparam int IDX_W = $clog2(DEPTH);

    IQEntry                  q_q [DEPTH];
    IQEntry                  q_d [DEPTH];
    logic [CNT_W-1:0]        occ_q, occ_d;
    UOPBundle                iss0_q, iss0_d, iss1_q, iss1_d;
    logic [DEPTH-1:0]        elig, a0only;
    logic                    g0, g1;
    logic [IDX_W-1:0]        idx0, idx1;
    UOPBundle                sel0, sel1;
    logic [3:0]              bv;
    logic [3:0][PRF_AW-1:0]  bt;
    logic                    enq_fire;
    IQEntry                  enq_e, upd;
    logic [CNT_W-1:0]        k;

    function automatic logic hit(input logic [PRF_AW-1:0] t, input logic [3:0] v,
                                 input logic [3:0][PRF_AW-1:0] tags);
        hit = 1'b0;
        for (int b = 0; b < 4; b++) hit |= v[b] && tags[b] == t;
    endfunction

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            elig[i]   = q_q[i].valid && q_q[i].src0_rdy && q_q[i].src1_rdy &&
                        (q_q[i].uop.aluType != ALU_CP0 || i == 0);
            a0only[i] = isAlu0Only(q_q[i].uop.aluType);
        end
    end

    iq_select #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_sel (
        .elig_i  (elig),
        .a0only_i(a0only),
        .g0_o    (g0),
        .idx0_o  (idx0),
        .g1_o    (g1),
        .idx1_o  (idx1)
    );

    assign sel0      = q_q[idx0].uop;
    assign sel1      = q_q[idx1].uop;
    // Own selections broadcast like writebacks so dependents issue back-to-back via bypass.
    assign bv        = {g1 && sel1.dstwe, g0 && sel0.dstwe, wake1.wen, wake0.wen};
    assign bt        = {sel1.dstPAddr, sel0.dstPAddr, wake1.rd, wake0.rd};
    assign enq_ready = occ_q < CNT_W'(DEPTH);
    assign enq_fire  = enq_valid && enq_ready && !flush;
    assign enq_e     = '{valid: 1'b1,
                         src0_rdy: !enq_uop.op0re || enq_src0_rdy || hit(enq_uop.op0PAddr, bv, bt),
                         src1_rdy: !enq_uop.op1re || enq_src1_rdy || hit(enq_uop.op1PAddr, bv, bt),
                         uop: enq_uop};

    always_comb begin
        k   = '0;
        upd = '0;
        for (int j = 0; j < DEPTH; j++) q_d[j] = '0;
        for (int i = 0; i < DEPTH; i++) begin
            upd          = q_q[i];
            upd.src0_rdy = upd.src0_rdy || hit(upd.uop.op0PAddr, bv, bt);
            upd.src1_rdy = upd.src1_rdy || hit(upd.uop.op1PAddr, bv, bt);
            if (upd.valid && !(g0 && idx0 == IDX_W'(i)) && !(g1 && idx1 == IDX_W'(i))) begin
                for (int j = 0; j < DEPTH; j++) if (k == CNT_W'(j)) q_d[j] = upd;
                k = k + 1'b1;
            end
        end
        for (int j = 0; j < DEPTH; j++) if (enq_fire && k == CNT_W'(j)) q_d[j] = enq_e;
        occ_d        = k + CNT_W'(enq_fire);
        iss0_d       = g0 ? sel0 : '0;
        iss0_d.valid = g0;
        iss1_d       = g1 ? sel1 : '0;
        iss1_d.valid = g1;
        if (flush) begin
            for (int j = 0; j < DEPTH; j++) q_d[j] = '0;
            occ_d  = '0;
            iss0_d = '0;
            iss1_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q    <= '{default: '0};
            occ_q  <= '0;
            iss0_q <= '0;
            iss1_q <= '0;
        end else begin
            q_q    <= q_d;
            occ_q  <= occ_d;
            iss0_q <= iss0_d;
            iss1_q <= iss1_d;
        end
    end

    assign occupancy = occ_q;
    assign iss0      = iss0_q;
    assign iss1      = iss1_q;
endmodule

// File: tb/tb_alu_issue_queue.sv
// tb_alu_issue_queue: scenario tasks with a per-slot scoreboard of expected issues.
module tb_alu_issue_queue;
    import alu_issue_queue_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n, flush, enq_valid, enq_src0_rdy, enq_src1_rdy, enq_ready;
    UOPBundle   enq_uop, iss0, iss1;
    PRFwInfo    wake0, wake1;
    logic [3:0] occupancy;
    int         errors = 0, checks = 0;
    UOPBundle   exp0[$], exp1[$];

    always #5 clk = ~clk;

    alu_issue_queue dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .enq_valid   (enq_valid),
        .enq_uop     (enq_uop),
        .enq_src0_rdy(enq_src0_rdy),
        .enq_src1_rdy(enq_src1_rdy),
        .enq_ready   (enq_ready),
        .wake0       (wake0),
        .wake1       (wake1),
        .iss0        (iss0),
        .iss1        (iss1),
        .occupancy   (occupancy)
    );

    function automatic UOPBundle mk(UOPType op, ALUType t, logic [5:0] s0, logic re0,
                                    logic [5:0] s1, logic re1, logic [5:0] d, logic we);
        UOPBundle u;
        u = '0;
        u.valid = 1'b1; u.uOP = op; u.aluType = t;
        u.op0PAddr = s0; u.op0re = re0; u.op1PAddr = s1; u.op1re = re1;
        u.dstPAddr = d; u.dstwe = we;
        return u;
    endfunction

    function automatic UOPBundle pop0();
        UOPBundle e = '0;
        if (exp0.size() != 0) e = exp0.pop_front();
        return e;
    endfunction

    function automatic UOPBundle pop1();
        UOPBundle e = '0;
        if (exp1.size() != 0) e = exp1.pop_front();
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        flush = 1'b0; enq_valid = 1'b0; enq_uop = '0;
        enq_src0_rdy = 1'b0; enq_src1_rdy = 1'b0;
        wake0 = '0; wake1 = '0;
    endtask

    task automatic enq(UOPBundle u, logic r0, logic r1);
        enq_valid = 1'b1; enq_uop = u; enq_src0_rdy = r0; enq_src1_rdy = r1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle();
        tick();
        tick();
        checks++; if (occupancy !== 4'd0) begin errors++; $display("FAIL reset_occ got %0d exp 0", occupancy); end
        checks++; if (iss0.valid !== 1'b0) begin errors++; $display("FAIL reset_iss0 got %b exp 0", iss0.valid); end
        checks++; if (iss1.valid !== 1'b0) begin errors++; $display("FAIL reset_iss1 got %b exp 0", iss1.valid); end
        checks++; if (enq_ready !== 1'b1) begin errors++; $display("FAIL reset_rdy got %b exp 1", enq_ready); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        UOPBundle u = mk(UOP_ADDU, ALU_ADD, 6'd1, 1'b1, 6'd2, 1'b1, 6'd5, 1'b1);
        UOPBundle e;
        enq(u, 1'b1, 1'b1); exp0.push_back(u);
        tick();
        idle();
        checks++; if (occupancy !== 4'd1) begin errors++; $display("FAIL single_occ1 got %0d exp 1", occupancy); end
        checks++; if (iss0.valid !== 1'b0) begin errors++; $display("FAIL single_early got %b exp 0", iss0.valid); end
        tick();
        e = pop0();
        checks++; if (iss0 !== e) begin errors++; $display("FAIL single_iss0 got %h exp %h", iss0, e); end
        checks++; if (iss1.valid !== 1'b0) begin errors++; $display("FAIL single_iss1 got %b exp 0", iss1.valid); end
        checks++; if (occupancy !== 4'd0) begin errors++; $display("FAIL single_occ0 got %0d exp 0", occupancy); end
    endtask

    task automatic test_back_to_back();
        UOPBundle a = mk(UOP_ADDU, ALU_ADD, 6'd1, 1'b1, 6'd2, 1'b1, 6'd10, 1'b1);
        UOPBundle b = mk(UOP_SUBU, ALU_ADD, 6'd10, 1'b1, 6'd3, 1'b1, 6'd11, 1'b1);
        UOPBundle e;
        enq(a, 1'b1, 1'b1); exp0.push_back(a);
        tick();
        enq(b, 1'b0, 1'b1); exp0.push_back(b);
        tick();
        idle();
        e = pop0();
        checks++; if (iss0 !== e) begin errors++; $display("FAIL b2b_producer got %h exp %h", iss0, e); end
        checks++; if (occupancy !== 4'd1) begin errors++; $display("FAIL b2b_occ got %0d exp 1", occupancy); end
        tick();
        e = pop0();
        checks++; if (iss0 !== e) begin errors++; $display("FAIL b2b_dependent got %h exp %h", iss0, e); end
        checks++; if (iss1.valid !== 1'b0) begin errors++; $display("FAIL b2b_iss1 got %b exp 0", iss1.valid); end
    endtask

    task automatic test_full();
        UOPBundle e;
        for (int i = 0; i < 8; i++) begin
            UOPBundle u = mk(UOP_ADDU, ALU_ADD, 6'd20, 1'b1, 6'd0, 1'b0, 6'(30 + i), 1'b1);
            enq(u, 1'b0, 1'b1);
            if (i % 2 == 0) exp0.push_back(u); else exp1.push_back(u);
            tick();
        end
        checks++; if (occupancy !== 4'd8) begin errors++; $display("FAIL full_occ got %0d exp 8", occupancy); end
        checks++; if (enq_ready !== 1'b0) begin errors++; $display("FAIL full_rdy got %b exp 0", enq_ready); end
        enq(mk(UOP_ADDU, ALU_ADD, 6'd1, 1'b0, 6'd1, 1'b0, 6'd63, 1'b1), 1'b1, 1'b1);
        tick();
        checks++; if (occupancy !== 4'd8) begin errors++; $display("FAIL full_held got %0d exp 8", occupancy); end
        idle();
        wake0 = '{wen: 1'b1, rd: 6'd20};
        tick();
        idle();
        checks++; if (iss0.valid !== 1'b0) begin errors++; $display("FAIL full_wake_early got %b exp 0", iss0.valid); end
        for (int c = 0; c < 4; c++) begin
            tick();
            e = pop0();
            checks++; if (iss0 !== e) begin errors++; $display("FAIL full_iss0[%0d] got %h exp %h", c, iss0, e); end
            e = pop1();
            checks++; if (iss1 !== e) begin errors++; $display("FAIL full_iss1[%0d] got %h exp %h", c, iss1, e); end
            checks++; if (occupancy !== 4'(6 - 2 * c)) begin errors++; $display("FAIL full_drain_occ[%0d] got %0d exp %0d", c, occupancy, 6 - 2 * c); end
            if (c == 0) begin
                checks++; if (enq_ready !== 1'b1) begin errors++; $display("FAIL full_rdy_after got %b exp 1", enq_ready); end
            end
        end
    endtask

    task automatic test_branch();
        UOPBundle br  = mk(UOP_BEQ, ALU_BRANCH, 6'd40, 1'b1, 6'd0, 1'b0, 6'd0, 1'b0);
        UOPBundle ori = mk(UOP_ORI, ALU_LOGIC, 6'd40, 1'b1, 6'd0, 1'b0, 6'd12, 1'b1);
        UOPBundle b1  = mk(UOP_BNE, ALU_BRANCH, 6'd41, 1'b1, 6'd7, 1'b0, 6'd0, 1'b0);
        UOPBundle b2  = mk(UOP_BEQ, ALU_BRANCH, 6'd41, 1'b1, 6'd8, 1'b0, 6'd0, 1'b0);
        UOPBundle e;
        enq(br, 1'b0, 1'b1); exp0.push_back(br); tick();
        enq(ori, 1'b0, 1'b1); exp1.push_back(ori); tick();
        idle(); wake0 = '{wen: 1'b1, rd: 6'd40}; tick();
        idle(); tick();
        e = pop0();
        checks++; if (iss0 !== e) begin errors++; $display("FAIL br_iss0 got %h exp %h", iss0, e); end
        e = pop1();
        checks++; if (iss1 !== e) begin errors++; $display("FAIL br_ori_iss1 got %h exp %h", iss1, e); end
        enq(b1, 1'b0, 1'b1); exp0.push_back(b1); tick();
        enq(b2, 1'b0, 1'b1); exp0.push_back(b2); tick();
        idle(); wake1 = '{wen: 1'b1, rd: 6'd41}; tick();
        idle();
        for (int c = 0; c < 2; c++) begin
            tick();
            e = pop0();
            checks++; if (iss0 !== e) begin errors++; $display("FAIL br2_iss0[%0d] got %h exp %h", c, iss0, e); end
            checks++; if (iss1.valid !== 1'b0) begin errors++; $display("FAIL br2_iss1[%0d] got %b exp 0", c, iss1.valid); end
        end
    endtask

    task automatic test_cp0();
        UOPBundle x = mk(UOP_ADDU, ALU_ADD, 6'd50, 1'b1, 6'd0, 1'b0, 6'd13, 1'b1);
        UOPBundle y = mk(UOP_ADDU, ALU_ADD, 6'd51, 1'b1, 6'd0, 1'b0, 6'd14, 1'b1);
        UOPBundle m = mk(UOP_MTC0, ALU_CP0, 6'd2, 1'b1, 6'd0, 1'b0, 6'd0, 1'b0);
        UOPBundle e;
        enq(x, 1'b0, 1'b1); exp0.push_back(x); tick();
        enq(y, 1'b0, 1'b1); exp1.push_back(y); tick();
        enq(m, 1'b1, 1'b1); exp0.push_back(m); tick();
        idle(); tick();
        checks++; if (iss0.valid !== 1'b0) begin errors++; $display("FAIL cp0_held got %b exp 0", iss0.valid); end
        wake0 = '{wen: 1'b1, rd: 6'd50};
        wake1 = '{wen: 1'b1, rd: 6'd51};
        tick();
        idle(); tick();
        e = pop0();
        checks++; if (iss0 !== e) begin errors++; $display("FAIL cp0_older0 got %h exp %h", iss0, e); end
        e = pop1();
        checks++; if (iss1 !== e) begin errors++; $display("FAIL cp0_older1 got %h exp %h", iss1, e); end
        tick();
        e = pop0();
        checks++; if (iss0 !== e) begin errors++; $display("FAIL cp0_issue got %h exp %h", iss0, e); end
        checks++; if (iss1.valid !== 1'b0) begin errors++; $display("FAIL cp0_iss1 got %b exp 0", iss1.valid); end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 5; i++) begin
            enq(mk(UOP_ADDU, ALU_ADD, 6'd60, 1'b1, 6'd0, 1'b0, 6'(15 + i), 1'b1), 1'b0, 1'b1);
            tick();
        end
        idle(); wake0 = '{wen: 1'b1, rd: 6'd60}; tick();
        idle();
        flush = 1'b1;
        enq(mk(UOP_ORI, ALU_LOGIC, 6'd1, 1'b0, 6'd0, 1'b0, 6'd22, 1'b1), 1'b1, 1'b1);
        tick();
        idle();
        checks++; if (occupancy !== 4'd0) begin errors++; $display("FAIL flush_occ got %0d exp 0", occupancy); end
        checks++; if (iss0.valid !== 1'b0) begin errors++; $display("FAIL flush_iss0 got %b exp 0", iss0.valid); end
        checks++; if (iss1.valid !== 1'b0) begin errors++; $display("FAIL flush_iss1 got %b exp 0", iss1.valid); end
        checks++; if (enq_ready !== 1'b1) begin errors++; $display("FAIL flush_rdy got %b exp 1", enq_ready); end
        tick();
        checks++; if (iss0.valid !== 1'b0) begin errors++; $display("FAIL flush_after got %b exp 0", iss0.valid); end
    endtask

    task automatic test_async_reset();
        UOPBundle r = mk(UOP_ADDU, ALU_ADD, 6'd1, 1'b0, 6'd0, 1'b0, 6'd24, 1'b1);
        UOPBundle e;
        enq(mk(UOP_ADDU, ALU_ADD, 6'd61, 1'b1, 6'd0, 1'b0, 6'd23, 1'b1), 1'b0, 1'b1); tick();
        enq(r, 1'b1, 1'b1); exp0.push_back(r); tick();
        idle(); tick();
        e = pop0();
        checks++; if (iss0 !== e) begin errors++; $display("FAIL arst_pre got %h exp %h", iss0, e); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (occupancy !== 4'd0) begin errors++; $display("FAIL arst_occ got %0d exp 0", occupancy); end
        checks++; if (iss0.valid !== 1'b0) begin errors++; $display("FAIL arst_iss0 got %b exp 0", iss0.valid); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_full();
        test_branch();
        test_cp0();
        test_flush();
        test_async_reset();
        checks++;
        if (exp0.size() != 0 || exp1.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_left got %0d/%0d exp 0/0", exp0.size(), exp1.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
